// File: rtl/wb_slave_router.sv
// wb_slave_router: Wishbone address-space router and sequencer for the user
// project area. Decodes each management-port cycle to one of NSLV slave
// windows, runs it downstream under a timeout watchdog, and returns the slave
// ack/data. Unmapped or stuck accesses get an error ack and set a sticky
// error flag (err_irq_o).
// Optional feature: define WB_DEBUG_REGS_EN to serve SCRATCH/STATUS debug
// registers from the top 8 bytes of the decoded space.
module wb_slave_router #(
    parameter int          NSLV     = 4,
    parameter int          SLV_AW   = 16,
    parameter logic [31:0] BASE     = 32'h3000_0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic [NSLV-1:0]    s_cyc_o,
    output logic               s_stb_o,
    output logic               s_we_o,
    output logic [3:0]         s_sel_o,
    output logic [31:0]        s_adr_o,
    output logic [31:0]        s_dat_o,
    input  logic [NSLV-1:0]    s_ack_i,
    input  logic [NSLV*32-1:0] s_dat_i,
    output logic               err_irq_o
);
    localparam int IW = $clog2(NSLV);
    localparam int TW = SLV_AW + IW;   // first address bit above the slave index

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ACK, S_ABORT} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NSLV-1:0] cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [3:0]      sel_q, sel_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     wdat_q, wdat_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdat_q, rdat_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [IW-1:0]   adr_idx;
    logic            adr_mapped;

    assign adr_idx    = wbs_adr_i[TW-1:SLV_AW];
    assign adr_mapped = (wbs_adr_i[31:TW] == BASE[31:TW]);

`ifdef WB_DEBUG_REGS_EN
    logic [31:0] scratch_q, scratch_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [3:0]  lerr_q, lerr_d;
    logic        dbg_hit;
    logic [31:0] status_w;

    // Top 8 bytes of the last slave window are the debug registers.
    assign dbg_hit  = adr_mapped && (adr_idx == IW'(NSLV - 1)) && (&wbs_adr_i[SLV_AW-1:3]);
    assign status_w = {tcnt_q, 8'h00, lerr_q, 3'b000, err_q};
`endif

    // Next-state and datapath decisions for the transfer sequencer.
    always_comb begin
        // NOTE: every _d starts from its held value so no branch can leave it unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        rdat_d  = rdat_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef WB_DEBUG_REGS_EN
        scratch_d = scratch_q;
        tcnt_d    = tcnt_q;
        lerr_d    = lerr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (!adr_mapped) begin
                        // Unmapped: error ack straight away, no slave is touched.
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        rdat_d  = ERR_DATA;
                        err_d   = 1'b1;
                    end
`ifdef WB_DEBUG_REGS_EN
                    else if (dbg_hit) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        if (wbs_we_i) begin
                            rdat_d = '0;
                            if (wbs_adr_i[2]) begin
                                if (wbs_dat_i[0]) begin
                                    err_d  = 1'b0;
                                    tcnt_d = '0;
                                end
                            end else begin
                                for (int b = 0; b < 4; b++) begin
                                    if (wbs_sel_i[b]) scratch_d[8*b +: 8] = wbs_dat_i[8*b +: 8];
                                end
                            end
                        end else begin
                            rdat_d = wbs_adr_i[2] ? status_w : scratch_q;
                        end
                    end
`endif
                    else begin
                        state_d        = S_REQ;
                        idx_d          = adr_idx;
                        cyc_d          = '0;
                        cyc_d[adr_idx] = 1'b1;
                        stb_d          = 1'b1;
                        we_d           = wbs_we_i;
                        sel_d          = wbs_sel_i;
                        adr_d          = wbs_adr_i;
                        wdat_d         = wbs_dat_i;
                        cnt_d          = '0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = '0;
                if (!wbs_cyc_i) begin
                    state_d = S_ABORT;
                    cyc_d   = '0;
                    stb_d   = 1'b0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Master abort outranks everything; a slave ack outranks the watchdog.
                if (!wbs_cyc_i) begin
                    state_d = S_ABORT;
                    cyc_d   = '0;
                    stb_d   = 1'b0;
                end else if (s_ack_i[idx_q]) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    rdat_d  = we_q ? 32'h0 : s_dat_i[32*idx_q +: 32];
                    cyc_d   = '0;
                    stb_d   = 1'b0;
                end else if (cnt_q == 16'(TIMEOUT)) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    rdat_d  = ERR_DATA;
                    err_d   = 1'b1;
                    cyc_d   = '0;
                    stb_d   = 1'b0;
`ifdef WB_DEBUG_REGS_EN
                    if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
                    lerr_d = 4'(idx_q);
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cyc_q   <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef WB_DEBUG_REGS_EN
            scratch_q <= '0;
            tcnt_q    <= '0;
            lerr_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            rdat_q  <= rdat_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef WB_DEBUG_REGS_EN
            scratch_q <= scratch_d;
            tcnt_q    <= tcnt_d;
            lerr_q    <= lerr_d;
`endif
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign s_cyc_o   = cyc_q;
    assign s_stb_o   = stb_q;
    assign s_we_o    = we_q;
    assign s_sel_o   = sel_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = wdat_q;
    assign err_irq_o = err_q;

endmodule

// File: tb/tb_wb_slave_router.sv
// tb_wb_slave_router: table-driven vectors plus hand sequences for timeout,
// ack-vs-timeout, stray acks, master abort and reset mid-transfer.
// A behavioural slave model answers s_cyc_o; an ack scoreboard checks every wbs_ack_o.
`timescale 1ns/1ps
module tb_wb_slave_router;
    localparam int          NSLV     = 4;
    localparam int          TIMEOUT  = 255;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic               wb_clk_i = 1'b0;
    logic               wb_rst_i;
    logic               wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]         wbs_sel_i;
    logic [31:0]        wbs_adr_i, wbs_dat_i;
    logic               wbs_ack_o;
    logic [31:0]        wbs_dat_o;
    logic [NSLV-1:0]    s_cyc_o;
    logic               s_stb_o, s_we_o;
    logic [3:0]         s_sel_o;
    logic [31:0]        s_adr_o, s_dat_o;
    logic [NSLV-1:0]    s_ack_i;
    logic [NSLV*32-1:0] s_dat_i;
    logic               err_irq_o;

    wb_slave_router #(
        .NSLV(NSLV), .SLV_AW(16), .BASE(32'h3000_0000), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .err_irq_o(err_irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct { logic [31:0] dat; logic err; } sb_t;
    typedef struct {
        logic            we;
        logic [31:0]     adr;
        logic [31:0]     wdat;
        logic [3:0]      sel;
        int              dly;
        logic [31:0]     exp_dat;
        logic [NSLV-1:0] exp_cyc;
        int              exp_lat;
        logic            exp_err;
    } vec_t;

    sb_t             sb_q[$];
    int              total = 0;
    int              bad = 0;
    int              cyc_n = 0;
    int              ack_seen = 0;
    int              cyc_hi = 0;
    int              xfer_start = 0;
    int              stray_rel = 0;
    logic [NSLV-1:0] stray_mask = '0;
    logic [NSLV-1:0] cyc_seen;
    int              dly[NSLV];
    int              age[NSLV];
    logic            cap_valid, cap_we, cap_stb;
    logic [3:0]      cap_sel;
    logic [31:0]     cap_adr, cap_dat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: observe at the falling edge, score acks, then update the slave model.
    task automatic tick();
        sb_t e;
        @(negedge wb_clk_i);
        cyc_n++;
        if (wbs_ack_o === 1'b1) begin
            ack_seen++;
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'(wbs_ack_o), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ack_data", wbs_dat_o, e.dat);
                check("ack_err", 32'(err_irq_o), 32'(e.err));
            end
        end
        if (s_cyc_o != '0) begin
            cyc_hi++;
            cyc_seen |= s_cyc_o;
            if (!cap_valid) begin
                cap_valid = 1'b1;
                cap_adr   = s_adr_o;
                cap_dat   = s_dat_o;
                cap_sel   = s_sel_o;
                cap_we    = s_we_o;
                cap_stb   = s_stb_o;
            end
        end
        // Slave k raises ack once its cyc has been high dly[k] cycles and holds it until cyc drops.
        s_ack_i = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (s_cyc_o[k]) begin
                age[k]++;
                if (dly[k] != 0 && age[k] >= dly[k]) s_ack_i[k] = 1'b1;
            end else begin
                age[k] = 0;
            end
        end
        if (stray_mask != '0 && (cyc_n - xfer_start) == stray_rel) s_ack_i |= stray_mask;
    endtask

    // Full master transfer: push expectation, hold cyc/stb until ack, then confirm a single ack pulse.
    task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input logic [31:0] exp_dat, input logic exp_err,
                           output int lat);
        sb_t e;
        int  base;
        e.dat = exp_dat;
        e.err = exp_err;
        sb_q.push_back(e);
        cyc_seen   = '0;
        cyc_hi     = 0;
        cap_valid  = 1'b0;
        base       = ack_seen;
        xfer_start = cyc_n;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        wbs_we_i   = we;
        wbs_adr_i  = adr;
        wbs_dat_i  = wdat;
        wbs_sel_i  = sel;
        lat = -1;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (ack_seen != base) begin
                lat = cyc_n - xfer_start;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        if (lat < 0) begin
            check("ack_wait_bound", 32'(ack_seen - base), 32'd1);
            sb_q.delete();
        end
        tick();
        tick();
        check("ack_pulse_count", 32'(ack_seen - base), 32'd1);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                                input logic [3:0] sel, input int d, input logic [31:0] exp_dat,
                                input logic [NSLV-1:0] exp_cyc, input int exp_lat, input logic exp_err);
        vec_t v;
        v.we = we; v.adr = adr; v.wdat = wdat; v.sel = sel; v.dly = d;
        v.exp_dat = exp_dat; v.exp_cyc = exp_cyc; v.exp_lat = exp_lat; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got 0x%08h expected 0x%08h", cyc_n, 0);
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vecs[$];
        int   lat;
        int   base;
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        s_ack_i   = '0;
        s_dat_i   = {32'hCAFE_F00D, 32'hC222_2222, 32'hB111_1111, 32'hA000_0000};
        cyc_seen  = '0;
        cap_valid = 1'b0;
        for (int k = 0; k < NSLV; k++) begin
            dly[k] = 0;
            age[k] = 0;
        end

        // Mapped accesses: latency is slave ack delay (in cycles of cyc) + 1; error-free.
        vecs.push_back(mk(1'b1, 32'h3001_0004, 32'h1234_5678, 4'hF, 3, 32'h0,         4'b0010, 4, 1'b0));
        vecs.push_back(mk(1'b0, 32'h3003_0000, 32'h0,         4'hF, 2, 32'hCAFE_F00D, 4'b1000, 3, 1'b0));
        vecs.push_back(mk(1'b0, 32'h3000_0010, 32'h0,         4'hF, 5, 32'hA000_0000, 4'b0001, 6, 1'b0));
        vecs.push_back(mk(1'b1, 32'h3002_FFFC, 32'h5566_7788, 4'h5, 2, 32'h0,         4'b0100, 3, 1'b0));
        vecs.push_back(mk(1'b0, 32'h3003_FFF8, 32'h0,         4'hF, 4, 32'hCAFE_F00D, 4'b1000, 5, 1'b0));
        // Unmapped: error ack one cycle after stb, no slave cycled; error then stays sticky.
        vecs.push_back(mk(1'b0, 32'h3100_0000, 32'h0,         4'hF, 2, ERR_DATA,      4'b0000, 1, 1'b1));
        vecs.push_back(mk(1'b0, 32'h3001_0000, 32'h0,         4'hF, 2, 32'hB111_1111, 4'b0010, 3, 1'b1));

        repeat (3) tick();
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_cyc", 32'(s_cyc_o), 32'd0);
        check("rst_stb", 32'(s_stb_o), 32'd0);
        check("rst_adr", s_adr_o, 32'd0);
        check("rst_err", 32'(err_irq_o), 32'd0);
        wb_rst_i = 1'b0;
        tick();

        foreach (vecs[i]) begin
            for (int k = 0; k < NSLV; k++) dly[k] = vecs[i].dly;
            do_xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].sel,
                    vecs[i].exp_dat, vecs[i].exp_err, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_s_cyc", i), 32'(cyc_seen), 32'(vecs[i].exp_cyc));
            if (vecs[i].exp_cyc != '0) begin
                check($sformatf("v%0d_s_adr", i), cap_adr, vecs[i].adr);
                check($sformatf("v%0d_s_we", i), 32'(cap_we), 32'(vecs[i].we));
                check($sformatf("v%0d_s_sel", i), 32'(cap_sel), 32'(vecs[i].sel));
                check($sformatf("v%0d_s_stb", i), 32'(cap_stb), 32'd1);
                if (vecs[i].we) check($sformatf("v%0d_s_dat", i), cap_dat, vecs[i].wdat);
            end
            check($sformatf("v%0d_dat_hold", i), wbs_dat_o, vecs[i].exp_dat);
        end

        // Fresh reset, then a slave that never acks: watchdog error ack.
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        tick();
        for (int k = 0; k < NSLV; k++) dly[k] = 0;
        do_xfer(1'b0, 32'h3002_0000, 32'h0, 4'hF, ERR_DATA, 1'b1, lat);
        check("timeout_latency", 32'(lat), 32'(TIMEOUT + 3));
        check("timeout_cyc_cycles", 32'(cyc_hi), 32'(TIMEOUT + 2));
        check("timeout_cyc_target", 32'(cyc_seen), 32'b0100);
        check("timeout_err_sticky", 32'(err_irq_o), 32'd1);

        // Reset mid-transfer: everything clears next cycle, no ack follows.
        base      = ack_seen;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h3001_0000;
        repeat (5) tick();
        wb_rst_i = 1'b1;
        tick();
        check("midrst_cyc", 32'(s_cyc_o), 32'd0);
        check("midrst_stb", 32'(s_stb_o), 32'd0);
        check("midrst_adr", s_adr_o, 32'd0);
        check("midrst_dat", wbs_dat_o, 32'd0);
        check("midrst_err", 32'(err_irq_o), 32'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wb_rst_i  = 1'b0;
        repeat (3) tick();
        check("midrst_no_ack", 32'(ack_seen - base), 32'd0);

        // Ack arriving in the very cycle the watchdog expires wins.
        dly[2] = TIMEOUT + 2;
        do_xfer(1'b0, 32'h3002_0000, 32'h0, 4'hF, 32'hC222_2222, 1'b0, lat);
        check("ack_vs_timeout_latency", 32'(lat), 32'(TIMEOUT + 3));

        // Acks from non-selected slaves are ignored.
        for (int k = 0; k < NSLV; k++) dly[k] = 6;
        stray_mask = 4'b1011;
        stray_rel  = 3;
        do_xfer(1'b0, 32'h3002_0010, 32'h0, 4'hF, 32'hC222_2222, 1'b0, lat);
        check("stray_ack_latency", 32'(lat), 32'd7);
        stray_mask = '0;

        // Master abort three cycles into WAIT, then a late slave ack: no master ack.
        dly[1]     = 10;
        base       = ack_seen;
        xfer_start = cyc_n;
        wbs_cyc_i  = 1'b1;
        wbs_stb_i  = 1'b1;
        wbs_we_i   = 1'b0;
        wbs_adr_i  = 32'h3001_0000;
        repeat (4) tick();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        tick();
        check("abort_cyc_drop", 32'(s_cyc_o), 32'd0);
        stray_mask = 4'b0010;
        stray_rel  = 8;
        repeat (10) tick();
        stray_mask = '0;
        check("abort_no_ack", 32'(ack_seen - base), 32'd0);
        dly[1] = 3;
        do_xfer(1'b0, 32'h3001_0000, 32'h0, 4'hF, 32'hB111_1111, 1'b0, lat);
        check("after_abort_latency", 32'(lat), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
